// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-memory access at a time and produces the MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] rd2,
    input  logic [4:0]  rd_addr,
    input  logic        write_reg,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_write_reg,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd_addr,
    output logic        misalign_exc
);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_r, state_s;
    logic        is_mem_s, trap_s, accept_s, complete_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        we_r, wreg_r, uns_r, exc_r, wb_valid_r, wb_wreg_r;
    logic [1:0]  size_r;
    logic [3:0]  be_r;
    logic [4:0]  rd_r, wb_rd_r;
    logic [31:0] addr_r, wdata_r, wb_data_r;

    // Select the byte lane(s) named by the byte enables and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [3:0] be,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (be)
            4'b0010: b = rdata[15:8];
            4'b0100: b = rdata[23:16];
            4'b1000: b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = be[2] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign is_mem_s = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_s;
    assign misaligned_s = ((mem_size == 2'b01) && alu_result[0]) ||
                          (mem_size[1] && (alu_result[1:0] != 2'b00));
    assign trap_s = valid_in & is_mem_s & misaligned_s & (state_r == IDLE);
`else
    assign trap_s = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = rd2;
        case (mem_size)
            2'b00: begin
                be_s    = 4'b0001 << alu_result[1:0];
                wdata_s = {4{rd2[7:0]}};
            end
            2'b01: begin
                be_s    = 4'b0011 << {alu_result[1], 1'b0};
                wdata_s = {2{rd2[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = rd2;
            end
        endcase
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_in && is_mem_s && !trap_s) begin
                    state_s  = ACCESS;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (dmem.dmem_ready) begin
                    state_s    = IDLE;
                    complete_s = 1'b1;
                end else begin
                    state_s = ACCESS;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request fields captured at acceptance, and the MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r       <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            be_r       <= 4'b0000;
            size_r     <= 2'b00;
            uns_r      <= 1'b0;
            rd_r       <= 5'd0;
            wreg_r     <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_wreg_r  <= 1'b0;
            wb_data_r  <= 32'h0000_0000;
            wb_rd_r    <= 5'd0;
            exc_r      <= 1'b0;
        end else begin
            wb_valid_r <= 1'b0;
            wb_wreg_r  <= 1'b0;
            exc_r      <= 1'b0;
            if (accept_s) begin
                we_r    <= mem_write;
                addr_r  <= {alu_result[31:2], 2'b00};
                wdata_r <= wdata_s;
                be_r    <= be_s;
                size_r  <= mem_size;
                uns_r   <= mem_unsigned;
                rd_r    <= rd_addr;
                wreg_r  <= write_reg;
            end
            if (complete_s) begin
                wb_valid_r <= 1'b1;
                wb_wreg_r  <= wreg_r & ~we_r;
                wb_rd_r    <= rd_r;
                if (!we_r) begin
                    wb_data_r <= load_extract(dmem.dmem_rdata, be_r, size_r, uns_r);
                end
            end else if ((state_r == IDLE) && valid_in && !is_mem_s) begin
                wb_valid_r <= 1'b1;
                wb_wreg_r  <= write_reg;
                wb_data_r  <= alu_result;
                wb_rd_r    <= rd_addr;
            end else if (trap_s) begin
                // Trapped access retires immediately without writing a register.
                wb_valid_r <= 1'b1;
                wb_rd_r    <= rd_addr;
                exc_r      <= 1'b1;
            end
        end
    end

    assign dmem.dmem_req   = (state_r == ACCESS);
    assign dmem.dmem_we    = we_r;
    assign dmem.dmem_addr  = addr_r;
    assign dmem.dmem_wdata = wdata_r;
    assign dmem.dmem_be    = be_r;

    assign mem_stall    = valid_in & is_mem_s & ~trap_s & ~((state_r == ACCESS) & dmem.dmem_ready);
    assign wb_valid     = wb_valid_r;
    assign wb_write_reg = wb_wreg_r;
    assign wb_data      = wb_data_r;
    assign wb_rd_addr   = wb_rd_r;
    assign misalign_exc = exc_r;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level reference model, randomized instruction stream, directed corner cases.
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] alu_result = 32'h0, rd2 = 32'h0;
    logic [4:0]  rd_addr = 5'd0;
    logic        write_reg = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_stall, wb_valid, wb_write_reg, misalign_exc;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;

    mem_stage_if dif ();

    mem_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result(alu_result), .rd2(rd2),
        .rd_addr(rd_addr), .write_reg(write_reg), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .dmem(dif.master),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_write_reg(wb_write_reg),
        .wb_data(wb_data), .wb_rd_addr(wb_rd_addr), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        wbv, wbw;
        logic [31:0] wbd;
        logic [4:0]  wbr;
        logic        exc;
    } out_t;

    typedef struct {
        logic        valid;
        logic [31:0] alu, rd2v, rdata;
        logic [4:0]  rd;
        logic        wreg, mrd, mwr, uns;
        logic [1:0]  size;
        int          wait_n, rst_at;
    } instr_t;

    out_t exp_o = '0, nxt_o = '0;
    logic exp_stall = 1'b0, busy = 1'b0, busy_n = 1'b0, chk_en = 1'b0;
    logic t_we = 1'b0, t_wreg = 1'b0, t_uns = 1'b0;
    logic [1:0] t_size = 2'b00, t_a = 2'b00;
    logic [4:0] t_rd = 5'd0;
    int n_cmp = 0, n_bad = 0;
    int stall_cnt = 0, wb_cnt = 0, req_cnt = 0;
    logic [31:0] last_data = 32'h0;
    logic [4:0]  last_rd = 5'd0;
    logic        last_wr = 1'b0, last_exc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int lane_of(input logic [1:0] size, input logic [1:0] a);
        if (size == 2'b00) return int'(a);
        if (size == 2'b01) return int'(a) & 2;
        return 0;
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] a);
        if (size == 2'b00) return 4'b0001 << lane_of(size, a);
        if (size == 2'b01) return 4'b0011 << lane_of(size, a);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [31:0] d, input logic [1:0] size);
        if (size == 2'b00) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (size == 2'b01) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] rdata, input logic [1:0] size,
                                        input logic [1:0] a, input logic uns);
        logic [31:0] v;
        v = rdata >> (8 * lane_of(size, a));
        if (size == 2'b00) begin
            v = v % 32'd256;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'b01) begin
            v = v % 32'd65536;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    // Transaction-level model: what the registered outputs must be after the coming edge.
    task automatic model_eval();
        logic mem, mis, trap;
        mem  = valid_in && (mem_read || mem_write);
        mis  = ((mem_size == 2'b01) && alu_result[0]) || (mem_size[1] && alu_result[1:0] != 2'b00);
        trap = TRAP && mem && mis;
        nxt_o = exp_o;
        nxt_o.wbv = 1'b0; nxt_o.wbw = 1'b0; nxt_o.exc = 1'b0;
        busy_n = busy;
        if (busy) begin
            exp_stall = mem && !dif.dmem_ready;
            if (dif.dmem_ready) begin
                busy_n = 1'b0;
                nxt_o.wbv = 1'b1;
                nxt_o.wbw = t_wreg && !t_we;
                nxt_o.wbr = t_rd;
                if (!t_we) nxt_o.wbd = ext(dif.dmem_rdata, t_size, t_a, t_uns);
            end
        end else begin
            exp_stall = mem && !trap;
            if (valid_in && !mem) begin
                nxt_o.wbv = 1'b1; nxt_o.wbw = write_reg; nxt_o.wbd = alu_result; nxt_o.wbr = rd_addr;
            end else if (trap) begin
                nxt_o.wbv = 1'b1; nxt_o.exc = 1'b1; nxt_o.wbr = rd_addr;
            end else if (mem) begin
                busy_n = 1'b1;
                nxt_o.we = mem_write;
                nxt_o.addr = alu_result & 32'hFFFF_FFFC;
                nxt_o.wdata = wdata_of(rd2, mem_size);
                nxt_o.be = be_of(mem_size, alu_result[1:0]);
                t_we = mem_write; t_wreg = write_reg; t_rd = rd_addr;
                t_size = mem_size; t_a = alu_result[1:0]; t_uns = mem_unsigned;
            end
        end
        if (rst) begin
            nxt_o = '0;
            busy_n = 1'b0;
        end
        nxt_o.req = busy_n;
    endtask

    task automatic tick(input logic r);
        rst = r;
        #1;
        model_eval();
        @(posedge clk);
        #1;
        exp_o = nxt_o;
        busy = busy_n;
        rst = 1'b0;
    endtask

    // Compare process: all DUT outputs against the model, once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dmem_req", dif.dmem_req, exp_o.req);
            chk("dmem_we", dif.dmem_we, exp_o.we);
            chk("dmem_addr", dif.dmem_addr, exp_o.addr);
            chk("dmem_wdata", dif.dmem_wdata, exp_o.wdata);
            chk("dmem_be", dif.dmem_be, exp_o.be);
            chk("wb_valid", wb_valid, exp_o.wbv);
            chk("wb_write_reg", wb_write_reg, exp_o.wbw);
            chk("wb_data", wb_data, exp_o.wbd);
            chk("wb_rd_addr", wb_rd_addr, exp_o.wbr);
            chk("misalign_exc", misalign_exc, exp_o.exc);
            chk("mem_stall", mem_stall, exp_stall);
            if (mem_stall) stall_cnt++;
            if (dif.dmem_req) req_cnt++;
            if (wb_valid) begin
                wb_cnt++;
                last_data = wb_data; last_rd = wb_rd_addr; last_wr = wb_write_reg; last_exc = misalign_exc;
            end
        end
    end

    function automatic instr_t mk(input logic v, input logic [31:0] alu, input logic [31:0] d,
                                  input logic [4:0] rd, input logic wreg, input logic mrd,
                                  input logic mwr, input logic [1:0] size, input logic uns,
                                  input int wait_n, input logic [31:0] rdata, input int rst_at);
        instr_t x;
        x.valid = v; x.alu = alu; x.rd2v = d; x.rd = rd; x.wreg = wreg; x.mrd = mrd; x.mwr = mwr;
        x.size = size; x.uns = uns; x.wait_n = wait_n; x.rdata = rdata; x.rst_at = rst_at;
        return x;
    endfunction

    task automatic clear_inputs();
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; write_reg = 1'b0;
    endtask

    task automatic idle();
        clear_inputs();
        dif.dmem_ready = 1'b0;
        tick(1'b0);
    endtask

    // Present one instruction, hold it while stalled, and act as the data memory.
    task automatic run(input instr_t in);
        int acc = 0;
        int guard = 0;
        logic done = 1'b0;
        valid_in = in.valid; alu_result = in.alu; rd2 = in.rd2v; rd_addr = in.rd;
        write_reg = in.wreg; mem_read = in.mrd; mem_write = in.mwr;
        mem_size = in.size; mem_unsigned = in.uns;
        while (!done) begin
            if (busy) begin
                acc++;
                if (in.rst_at != 0 && acc == in.rst_at) begin
                    dif.dmem_ready = 1'b0;
                    tick(1'b1);
                    clear_inputs();
                    dif.dmem_ready = 1'b1;
                    dif.dmem_rdata = $urandom;
                    tick(1'b0);
                    dif.dmem_ready = 1'b0;
                    return;
                end
                dif.dmem_ready = (acc > in.wait_n);
                dif.dmem_rdata = in.rdata;
            end else begin
                dif.dmem_ready = ($urandom_range(0, 3) == 0);
                dif.dmem_rdata = $urandom;
            end
            tick(1'b0);
            done = !exp_stall;
            guard++;
            if (guard > 40) begin
                n_cmp++; n_bad++;
                $display("FAIL timeout: instruction still stalled after %0d cycles", guard);
                done = 1'b1;
            end
        end
        dif.dmem_ready = 1'b0;
    endtask

    int s0, w0, r0;

    initial begin
        dif.dmem_ready = 1'b0;
        dif.dmem_rdata = 32'h0;
        tick(1'b1);
        chk_en = 1'b1;
        tick(1'b1);
        idle();

        // Model pins against hand-computed values.
        chk("pin_be_sb", be_of(2'b00, 2'b10), 32'h4);
        chk("pin_wdata_sb", wdata_of(32'h0000_00AB, 2'b00), 32'hABAB_ABAB);
        chk("pin_lb", ext(32'h80FF_FFFF, 2'b00, 2'b11, 1'b0), 32'hFFFF_FF80);
        chk("pin_lbu", ext(32'h80FF_FFFF, 2'b00, 2'b11, 1'b1), 32'h0000_0080);
        chk("pin_be_lh", be_of(2'b01, 2'b01), 32'h3);
        chk("pin_lh_hi", ext(32'h8001_1234, 2'b01, 2'b10, 1'b0), 32'hFFFF_8001);

        // ADD result to rd=5.
        s0 = stall_cnt; w0 = wb_cnt;
        run(mk(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0, 0));
        idle();
        chk("add_data", last_data, 32'h0000_1234);
        chk("add_rd", last_rd, 32'd5);
        chk("add_stalls", stall_cnt - s0, 32'd0);
        chk("add_wb_count", wb_cnt - w0, 32'd1);

        // SB 0xAB at 0x102 with three wait cycles.
        s0 = stall_cnt;
        run(mk(1'b1, 32'h0000_0102, 32'h0000_00AB, 5'd9, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3, 32'h0, 0));
        idle();
        chk("sb_stalls", stall_cnt - s0, 32'd4);
        chk("sb_addr", dif.dmem_addr, 32'h0000_0100);
        chk("sb_be", dif.dmem_be, 32'h4);
        chk("sb_wdata", dif.dmem_wdata, 32'hABAB_ABAB);
        chk("sb_write_reg", last_wr, 32'd0);

        // LB / LBU at 0x103.
        run(mk(1'b1, 32'h0000_0103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 32'h80FF_FFFF, 0));
        idle();
        chk("lb_data", last_data, 32'hFFFF_FF80);
        run(mk(1'b1, 32'h0000_0103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 0, 32'h80FF_FFFF, 0));
        idle();
        chk("lbu_data", last_data, 32'h0000_0080);

        // LW 0x200 aborted by reset in its second access cycle.
        w0 = wb_cnt;
        run(mk(1'b1, 32'h0000_0200, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 9, 32'h1111_2222, 2));
        chk("abort_req", dif.dmem_req, 32'd0);
        idle();
        chk("abort_no_wb", wb_cnt - w0, 32'd0);

        // LH at odd address 0x201.
        r0 = req_cnt;
        run(mk(1'b1, 32'h0000_0201, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1, 32'h5555_AAAA, 0));
        idle();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lh_exc", last_exc, 32'd1);
        chk("lh_no_req", req_cnt - r0, 32'd0);
`else
        chk("lh_addr", dif.dmem_addr, 32'h0000_0200);
        chk("lh_be", dif.dmem_be, 32'h3);
`endif

        // LW 0x10 followed immediately by an ADD.
        w0 = wb_cnt;
        run(mk(1'b1, 32'h0000_0010, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2, 32'hCAFE_F00D, 0));
        run(mk(1'b1, 32'h0000_0055, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0, 0));
        idle();
        chk("b2b_wb_count", wb_cnt - w0, 32'd2);
        chk("b2b_last", last_data, 32'h0000_0055);

        // Randomized instruction stream.
        for (int i = 0; i < 400; i++) begin
            int k, wt, ra;
            logic mrd, mwr;
            k   = $urandom_range(0, 9);
            mrd = (k >= 4 && k <= 6) || k == 9;
            mwr = (k >= 7);
            wt  = $urandom_range(0, 4);
            ra  = 0;
            if ((mrd || mwr) && $urandom_range(0, 19) == 0) begin
                ra = $urandom_range(1, 2);
                wt = 6;
            end
            run(mk(k != 0, $urandom, $urandom, 5'($urandom), 1'($urandom), mrd, mwr,
                   2'($urandom), 1'($urandom), wt, $urandom, ra));
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 valid_in  in  1  EX/MEM register holds a valid instruction.
REQ-004 alu_result  in  32  effective address, or result for non-memory instructions.
REQ-005 rd2  in  32  store data.
REQ-006 rd_addr  in  5  destination register.
REQ-007 write_reg  in  1  instruction writes rd.
REQ-008 mem_read / mem_write  in  1 each  load / store; both high treated as store.
REQ-009 mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-010 mem_unsigned  in  1  zero-extend loads (LBU/LHU).
REQ-011 dmem_req  out  1  data-memory request, held until accepted.
REQ-012 dmem_we  out  1  request is a write.
REQ-013 dmem_addr  out  32  word-aligned address (bits [1:0] = 00).
REQ-014 dmem_wdata  out  32  lane-replicated store data.
REQ-015 dmem_be  out  4  byte enables.
REQ-016 dmem_ready  in  1  memory completes the current request this cycle.
REQ-017 dmem_rdata  in  32  read word; valid when dmem_ready is high on a read.
REQ-018 mem_stall  out  1  upstream SHALL hold the EX/MEM register and its inputs while high.
REQ-019 wb_valid, wb_write_reg  out  1 each  MEM/WB valid and write enable.
REQ-020 wb_data  out  32  load result or passed-through alu_result.
REQ-021 wb_rd_addr  out  5  destination register.
REQ-022 misalign_exc  out  1  one-cycle misaligned-access flag (see Configuration).

Function
REQ-023 FSM states: IDLE and ACCESS.
- IDLE -> ACCESS: valid_in, memory operation, not trapped.
- ACCESS -> IDLE: on the cycle dmem_ready is high.
REQ-024 On the IDLE->ACCESS edge, register dmem_addr, dmem_we, dmem_wdata, dmem_be, the load-extract controls and the destination fields; hold them stable for the whole of ACCESS.
REQ-025 dmem_req = 1 exactly while in ACCESS.
REQ-026 mem_stall is combinational: valid_in & (mem_read|mem_write) & !(state==ACCESS & dmem_ready).
REQ-027 Non-memory instruction (valid_in, no mem op): register wb_* next edge (wb_data = alu_result); latency 1; no stall.
REQ-028 Memory op minimum latency: accepted at edge N, dmem_req high in cycle N+1; dmem_ready in cycle N+k gives wb_valid in cycle N+k+1 for exactly 1 cycle.
REQ-029 Store completion: wb_valid=1, wb_write_reg=0.
REQ-030 Byte enables, with a = address[1:0]:
- byte: 0001<<a
- half: 0011<<(2*a[1])
- word: 1111
REQ-031 Write data: byte replicated ×4, half ×2, word unchanged.
REQ-032 Load extract: select the lane indicated by the byte enables from dmem_rdata; sign-extend unless mem_unsigned; word passes through.
REQ-033 Cycles with valid_in=0 and no completion: wb_valid=0 and wb_write_reg=0; wb_data and wb_rd_addr hold.
REQ-034 dmem_ready while in IDLE is ignored.

Reset
REQ-035 rst at any cycle, including mid-ACCESS:
- FSM -> IDLE.
- dmem_req, dmem_we, dmem_be = 0.
- dmem_addr, dmem_wdata, wb_data = 0.
- wb_valid, wb_write_reg, misalign_exc = 0.
- wb_rd_addr = 0.
REQ-036 A response arriving after rst aborts an access is discarded.

Configuration
REQ-037 Macro MEM_MISALIGN_TRAP_EN. A misaligned access is a half with address[0]=1 or a word with address[1:0]≠00.
REQ-038 With MEM_MISALIGN_TRAP_EN defined, a misaligned access:
- issues no dmem request and does not stall;
- next edge: misalign_exc=1 for one cycle, wb_valid=1, wb_write_reg=0.
REQ-039 Without MEM_MISALIGN_TRAP_EN:
- misalign_exc is tied 0;
- offending low address bits are ignored (half uses address[1] only; word uses 00), and the access proceeds aligned.

Verification
REQ-040 ADD result 0x0000_1234 to rd=5, write_reg=1 -> next cycle wb_valid=1, wb_data=0x0000_1234, wb_rd_addr=5, mem_stall never high.
REQ-041 SB rd2=0x0000_00AB at addr 0x102, dmem_ready after 3 wait cycles -> dmem_be=0100, dmem_wdata=0xABAB_ABAB, dmem_addr=0x100, mem_stall high 4 cycles, wb_write_reg=0.
REQ-042 LB addr 0x103, dmem_rdata=0x80FF_FFFF, ready immediately -> wb_data=0xFFFF_FF80; repeat as LBU -> 0x0000_0080.
REQ-043 LW addr 0x200, rst asserted in the 2nd ACCESS cycle, dmem_ready the cycle after -> dmem_req=0 after the reset edge, no wb_valid, FSM IDLE.
REQ-044 LH addr 0x201 -> with MEM_MISALIGN_TRAP_EN: misalign_exc=1, dmem_req stays 0; without: dmem_addr=0x200, dmem_be=0011.
REQ-045 Back-to-back LW 0x10 then ADD: the ADD is held until the LW completes; wb_valid pulses on consecutive completions, in order.
